// File: rtl/afifo_rd_drain.sv
// Read-domain drain engine for the async FIFO: pops via rinc/rempty into a 2-entry skid buffer feeding a valid/ready stream.
// Define AFIFO_DRAIN_CHECK_EN to build the incrementing-pattern data checker that drives err.
module afifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  pop_count,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                            state, state_nxt;
  logic                              done_nxt;
  logic [LEN_WIDTH-1:0]              remaining;
  logic                              cont;
  logic                              inflight;
  logic [1:0]                        buf_cnt;
  logic [1:0][DATA_WIDTH-1:0]        buf_mem;
  logic                              wr_ptr, rd_ptr;
  logic                              push, pull, credit_ok, len_ok, last_pop, flush_empty, go;

  // Credit counts the word already in flight so a capture never lands in a full buffer.
  assign credit_ok   = (buf_cnt + {1'b0, inflight}) < 2'd2;
  assign len_ok      = cont || (remaining != '0);
  assign rinc        = (state == RUN) && !rempty && credit_ok && len_ok && !rrst;
  assign push        = inflight;
  assign pull        = m_valid && m_ready;
  assign last_pop    = rinc && !cont && (remaining == LEN_WIDTH'(1));
  assign flush_empty = !inflight && (buf_cnt == 2'd0);
  assign go          = (state == IDLE) && start;

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf_mem[rd_ptr];
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (stop || last_pop) state_nxt = FLUSH;
      FLUSH: if (flush_empty) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state     <= IDLE;
      done      <= 1'b0;
      inflight  <= 1'b0;
      buf_cnt   <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      remaining <= '0;
      cont      <= 1'b0;
      pop_count <= '0;
    end else begin
      state    <= state_nxt;
      done     <= done_nxt;
      inflight <= rinc;
      if (go) begin
        remaining <= burst_len;
        cont      <= (burst_len == '0);
        pop_count <= '0;
      end else if (rinc) begin
        pop_count <= pop_count + LEN_WIDTH'(1);
        if (!cont) remaining <= remaining - LEN_WIDTH'(1);
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pull) rd_ptr <= ~rd_ptr;
      case ({push, pull})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Data storage needs no reset; buf_cnt qualifies it.
  always_ff @(posedge rclk) begin
    if (push) buf_mem[wr_ptr] <= rdata;
  end

`ifdef AFIFO_DRAIN_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  exp_vld;
  logic                  err_q;

  // Expectation always follows the received word, so one bad word flags once and resyncs.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      exp_vld  <= 1'b0;
      exp_data <= '0;
      err_q    <= 1'b0;
    end else if (go) begin
      exp_vld <= 1'b0;
      err_q   <= 1'b0;
    end else if (push) begin
      exp_vld  <= 1'b1;
      exp_data <= rdata + DATA_WIDTH'(1);
      if (exp_vld && (rdata != exp_data)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
